stepper_step_gen: RTL and testbench

Command-driven step/direction generator that sits directly upstream of the stepper phase driver. It accepts a move command through a valid/ready handshake and emits `rotate_pulse`, `direction`, `module_enable` and `vref_level` for the driver stage. Each move follows a linear-period trapezoidal acceleration profile. An optional reduced-current hold phase runs after each move.

---
 rtl/stepper_step_gen.sv | 181 ++++++++++++++++++
 tb/tb_stepper_step_gen.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stepper_step_gen.sv
// rtl/stepper_step_gen.sv - command-driven trapezoidal step/direction generator for the stepper phase driver
// Optional reduced-current hold after each move is built in when STEPPER_STEP_GEN_HOLD_EN is defined.
module stepper_step_gen #(
  parameter int PERIOD_W = 24,
  parameter int STEP_W = 16,
  parameter int PULSE_W = 8,
  parameter int SETTLE = 16,
  parameter logic [3:0] RUN_VREF = 4'd15
`ifdef STEPPER_STEP_GEN_HOLD_EN
  , parameter logic [3:0] HOLD_VREF = 4'd4,
  parameter int HOLD_CYCLES = 1000
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [STEP_W-1:0]   cmd_steps,
  input  logic                cmd_dir,
  input  logic [PERIOD_W-1:0] cmd_period_start,
  input  logic [PERIOD_W-1:0] cmd_period_min,
  input  logic [PERIOD_W-1:0] cmd_accel,
  input  logic                abort,
  output logic                rotate_pulse,
  output logic                direction,
  output logic                module_enable,
  output logic [3:0]          vref_level,
  output logic                busy,
  output logic                done
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETTLE, ST_ACCEL, ST_CRUISE, ST_DECEL
`ifdef STEPPER_STEP_GEN_HOLD_EN
    , ST_HOLD
`endif
  } state_t;

  localparam logic [PERIOD_W-1:0] PERIOD_FLOOR = PERIOD_W'(2 * PULSE_W);
`ifdef STEPPER_STEP_GEN_HOLD_EN
  localparam int HC_W = $clog2(HOLD_CYCLES + 1);
  logic [HC_W-1:0] hold_cnt;
`endif

  state_t              state;
  logic [PERIOD_W-1:0] period, start_r, min_r, accel_r, cnt;
  logic [STEP_W-1:0]   rem, ramp;
  logic                abort_pend;

  logic [PERIOD_W-1:0] min_clamped, start_clamped, accel_next, decel_next;
  logic [PERIOD_W:0]   up_sum, dn_diff;
  logic                accept, boundary, stop_now, accel_ok;

  always_comb begin
    min_clamped   = (cmd_period_min < PERIOD_FLOOR) ? PERIOD_FLOOR : cmd_period_min;
    start_clamped = (cmd_period_start < min_clamped) ? min_clamped : cmd_period_start;
    // Ramp arithmetic is one bit wider so neither direction can wrap.
    up_sum     = {1'b0, period} + {1'b0, accel_r};
    dn_diff    = {1'b0, period} - {1'b0, accel_r};
    decel_next = (up_sum > {1'b0, start_r}) ? start_r : up_sum[PERIOD_W-1:0];
    accel_next = (dn_diff[PERIOD_W] || (dn_diff[PERIOD_W-1:0] < min_r)) ? min_r : dn_diff[PERIOD_W-1:0];
    // Only speed up while enough steps remain to ramp back down symmetrically.
    accel_ok   = (period > min_r) && ({2'b00, rem} >= ({2'b00, ramp} + (STEP_W + 2)'(2)));
    accept     = cmd_valid && cmd_ready;
    boundary   = 1'b0;
    case (state)
      ST_SETTLE:                     boundary = (cnt == '0);
      ST_ACCEL, ST_CRUISE, ST_DECEL: boundary = (cnt == period);
      default:                       boundary = 1'b0;
    endcase
    stop_now = boundary && (abort_pend || abort || (rem == '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      cmd_ready     <= 1'b0;
      rotate_pulse  <= 1'b0;
      direction     <= 1'b0;
      module_enable <= 1'b0;
      vref_level    <= 4'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
      period        <= '0;
      start_r       <= '0;
      min_r         <= '0;
      accel_r       <= '0;
      cnt           <= '0;
      rem           <= '0;
      ramp          <= '0;
      abort_pend    <= 1'b0;
`ifdef STEPPER_STEP_GEN_HOLD_EN
      hold_cnt      <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (busy && abort) abort_pend <= 1'b1;
      if (accept) begin
        if (cmd_steps == '0) begin
          done <= 1'b1;
        end else begin
          state         <= ST_SETTLE;
          cmd_ready     <= 1'b0;
          module_enable <= 1'b1;
          busy          <= 1'b1;
          vref_level    <= RUN_VREF;
          direction     <= cmd_dir;
          rem           <= cmd_steps;
          start_r       <= start_clamped;
          min_r         <= min_clamped;
          accel_r       <= cmd_accel;
          cnt           <= PERIOD_W'(SETTLE - 1);
          abort_pend    <= 1'b0;
        end
      end else if (stop_now) begin
        done       <= 1'b1;
        busy       <= 1'b0;
        cmd_ready  <= 1'b1;
        abort_pend <= 1'b0;
`ifdef STEPPER_STEP_GEN_HOLD_EN
        state      <= ST_HOLD;
        vref_level <= HOLD_VREF;
        hold_cnt   <= HC_W'(HOLD_CYCLES - 1);
`else
        state         <= ST_IDLE;
        module_enable <= 1'b0;
        vref_level    <= 4'd0;
`endif
      end else begin
        case (state)
          ST_IDLE: cmd_ready <= 1'b1;
          ST_SETTLE: begin
            if (boundary) begin
              rotate_pulse <= 1'b1;
              cnt          <= PERIOD_W'(1);
              period       <= start_r;
              rem          <= rem - 1'b1;
              ramp         <= '0;
              state        <= (start_r > min_r) ? ST_ACCEL : ST_CRUISE;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          ST_ACCEL, ST_CRUISE, ST_DECEL: begin
            if (boundary) begin
              rotate_pulse <= 1'b1;
              cnt          <= PERIOD_W'(1);
              rem          <= rem - 1'b1;
              if (rem <= ramp) begin
                state  <= ST_DECEL;
                period <= decel_next;
              end else if (accel_ok) begin
                state  <= ST_ACCEL;
                period <= accel_next;
                ramp   <= ramp + 1'b1;
              end else begin
                state <= ST_CRUISE;
              end
            end else begin
              cnt <= cnt + 1'b1;
              if (cnt == PERIOD_W'(PULSE_W)) rotate_pulse <= 1'b0;
            end
          end
`ifdef STEPPER_STEP_GEN_HOLD_EN
          ST_HOLD: begin
            if (hold_cnt == '0) begin
              state         <= ST_IDLE;
              module_enable <= 1'b0;
              vref_level    <= 4'd0;
            end else begin
              hold_cnt <= hold_cnt - 1'b1;
            end
          end
`endif
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stepper_step_gen.sv
// tb/tb_stepper_step_gen.sv - scoreboard bench for stepper_step_gen with a profile-level reference model
module tb_stepper_step_gen;
  localparam int PW  = 8;
  localparam int SET = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_steps = '0;
  logic        cmd_dir = 1'b0;
  logic [23:0] cmd_period_start = '0;
  logic [23:0] cmd_period_min = '0;
  logic [23:0] cmd_accel = '0;
  logic        abort = 1'b0;
  logic        rotate_pulse, direction, module_enable, busy, done;
  logic [3:0]  vref_level;

  stepper_step_gen dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_steps(cmd_steps), .cmd_dir(cmd_dir), .cmd_period_start(cmd_period_start),
    .cmd_period_min(cmd_period_min), .cmd_accel(cmd_accel), .abort(abort),
    .rotate_pulse(rotate_pulse), .direction(direction), .module_enable(module_enable),
    .vref_level(vref_level), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit     is_done;
    longint at;
    longint en;
    longint vref;
  } ev_t;

  int     total = 0;
  int     bad = 0;
  longint cyc = 0;
  ev_t    exp_q[$];
  longint prof[$];
  longint exp_dir = 0;
  int     rises = 0;
  longint last_done = 0;
  bit     en_watch = 0;
  int     en_drops = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, longint act, longint expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Whole-move period list: ramp down from the clamped start by accel, limited so the
  // ramp-up and ramp-down have equal step counts, cruise in between, ramp back up capped at start.
  function automatic void build_profile(int n, longint st, longint mn, longint ac);
    longint mc, sc, r, k, uk, u;
    prof.delete();
    mc = (mn < 2 * PW) ? 2 * PW : mn;
    sc = (st < mc) ? mc : st;
    r  = (ac == 0) ? longint'(n) : (sc - mc + ac - 1) / ac;
    k  = (n > 0) ? longint'((n - 1) / 2) : 0;
    if (r < k) k = r;
    for (longint i = 0; i < k; i++) begin
      u = sc - i * ac;
      prof.push_back((u < mc) ? mc : u);
    end
    uk = sc - k * ac;
    if (uk < mc) uk = mc;
    for (longint i = 0; i < longint'(n) - 2 * k; i++) prof.push_back(uk);
    for (longint j = 1; j <= k; j++) prof.push_back((uk + j * ac > sc) ? sc : uk + j * ac);
  endfunction

  always @(negedge clk) begin : monitor
    ev_t e;
    bit  prev_p;
    int  width;
    if (!rst_n) begin
      prev_p = 1'b0;
      width  = 0;
    end else begin
      if (rotate_pulse && !prev_p) begin
        rises++;
        if (exp_q.size() == 0 || exp_q[0].is_done) begin
          total++; bad++;
          $display("FAIL unexpected_pulse at cycle %0d", cyc);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_time", cyc, e.at);
          chk("pulse_enable", longint'(module_enable), 1);
          chk("pulse_vref", longint'(vref_level), 15);
          chk("pulse_busy", longint'(busy), 1);
          chk("pulse_dir", longint'(direction), exp_dir);
        end
      end
      if (rotate_pulse) width++;
      else if (prev_p) begin
        chk("pulse_width", longint'(width), PW);
        width = 0;
      end
      prev_p = rotate_pulse;
      if (done) begin
        last_done = cyc;
        if (exp_q.size() == 0 || !exp_q[0].is_done) begin
          total++; bad++;
          $display("FAIL unexpected_done at cycle %0d", cyc);
        end else begin
          e = exp_q.pop_front();
          chk("done_time", cyc, e.at);
          chk("done_enable", longint'(module_enable), e.en);
          chk("done_vref", longint'(vref_level), e.vref);
          chk("done_busy", longint'(busy), 0);
          chk("done_ready", longint'(cmd_ready), 1);
        end
      end
    end
  end

  always @(negedge clk) if (en_watch && rst_n && !module_enable) en_drops++;

  task automatic issue(int n, longint st, longint mn, longint ac, bit dir,
                       int abort_at, bit abort_last, bit wait_end);
    ev_t    e;
    longint a, t;
    int     k, i;
    build_profile(n, st, mn, ac);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_steps = 16'(n);
    cmd_dir = dir;
    cmd_period_start = 24'(st);
    cmd_period_min = 24'(mn);
    cmd_accel = 24'(ac);
    for (i = 0; i < 3000 && !cmd_ready; i++) @(negedge clk);
    if (!cmd_ready) begin
      total++; bad++;
      $display("FAIL ready_timeout at cycle %0d", cyc);
      cmd_valid = 1'b0;
      return;
    end
    exp_dir = longint'(dir);
    rises = 0;
    a = cyc + 1;
    k = (abort_at > 0 && abort_at < n) ? abort_at : n;
    t = a + SET;
    for (i = 0; i < k; i++) begin
      e.is_done = 0; e.at = t; e.en = 1; e.vref = 15;
      exp_q.push_back(e);
      t += prof[i];
    end
    e.is_done = 1;
    if (n == 0) begin
      e.at = a; e.en = 0; e.vref = 0;
    end else begin
      e.at = t;
`ifdef STEPPER_STEP_GEN_HOLD_EN
      e.en = 1; e.vref = 4;
`else
      e.en = 0; e.vref = 0;
`endif
    end
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    if (abort_at > 0) begin
      for (i = 0; i < 20000 && rises < abort_at; i++) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
    end
    if (abort_last) begin
      for (i = 0; i < 20000 && cyc < t - 1; i++) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
    end
    if (!wait_end) return;
    for (i = 0; i < 30000 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL move_timeout pending=%0d at cycle %0d", exp_q.size(), cyc);
      exp_q.delete();
    end
    chk("pulse_count", longint'(rises), longint'(k));
  endtask

  initial begin : main
    bit seen;
    int n, ab;
    repeat (3) @(negedge clk);
    chk("reset_pulse", longint'(rotate_pulse), 0);
    chk("reset_dir", longint'(direction), 0);
    chk("reset_enable", longint'(module_enable), 0);
    chk("reset_vref", longint'(vref_level), 0);
    chk("reset_busy", longint'(busy), 0);
    chk("reset_done", longint'(done), 0);
    chk("reset_ready", longint'(cmd_ready), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", longint'(cmd_ready), 1);

    issue(5, 100, 100, 10, 1'b1, 0, 1'b0, 1'b1);
    issue(20, 100, 60, 10, 1'b0, 0, 1'b0, 1'b1);
    issue(4, 100, 20, 10, 1'b1, 0, 1'b0, 1'b1);
    issue(50, 100, 100, 10, 1'b0, 3, 1'b0, 1'b1);
    issue(3, 60, 60, 5, 1'b1, 0, 1'b1, 1'b1);
    issue(4, 5, 3, 2, 1'b0, 0, 1'b0, 1'b1);
`ifdef STEPPER_STEP_GEN_HOLD_EN
    repeat (1010) @(negedge clk);
`endif
    issue(0, 50, 50, 0, 1'b1, 0, 1'b0, 1'b1);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (module_enable) seen = 1;
    end
    chk("zero_step_enable", longint'(seen), 0);

    abort = 1'b1;
    repeat (5) @(negedge clk);
    abort = 1'b0;
    issue(3, 40, 40, 0, 1'b0, 0, 1'b0, 1'b1);

    repeat (12) begin
      n  = $urandom_range(1, 10);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, n) : 0;
      issue(n, longint'($urandom_range(10, 120)), longint'($urandom_range(0, 100)),
            longint'($urandom_range(0, 25)), 1'($urandom_range(0, 1)), ab, 1'b0, 1'b1);
    end

`ifdef STEPPER_STEP_GEN_HOLD_EN
    issue(3, 40, 40, 0, 1'b1, 0, 1'b0, 1'b1);
    while (cyc < last_done + 999) @(negedge clk);
    chk("hold_vref", longint'(vref_level), 4);
    chk("hold_enable", longint'(module_enable), 1);
    @(negedge clk);
    chk("hold_end_enable", longint'(module_enable), 0);
    chk("hold_end_vref", longint'(vref_level), 0);
    issue(3, 40, 40, 0, 1'b0, 0, 1'b0, 1'b1);
    repeat (300) @(negedge clk);
    en_watch = 1'b1;
    issue(4, 50, 30, 10, 1'b1, 0, 1'b0, 1'b1);
    en_watch = 1'b0;
    chk("hold_enable_continuous", longint'(en_drops), 0);
    repeat (1010) @(negedge clk);
`endif

    issue(10, 100, 100, 0, 1'b1, 0, 1'b0, 1'b0);
    for (int i = 0; i < 3000 && !(rises >= 2 && rotate_pulse); i++) @(negedge clk);
    chk("pulse_before_reset", longint'(rotate_pulse), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset_pulse", longint'(rotate_pulse), 0);
    chk("async_reset_enable", longint'(module_enable), 0);
    chk("async_reset_busy", longint'(busy), 0);
    chk("async_reset_vref", longint'(vref_level), 0);
    chk("async_reset_dir", longint'(direction), 0);
    chk("async_reset_ready", longint'(cmd_ready), 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    issue(2, 30, 20, 5, 1'b0, 0, 1'b0, 1'b1);

    chk("queue_empty", longint'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
